// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port system-memory arbiter.
package mem_arb_pkg;

    localparam int MA_ADDR_W  = 14;
    localparam int MA_WDATA_W = 16;
    localparam int MA_RDATA_W = 8;
    localparam int MA_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // On a tie the port that did not win last time gets the memory.
    function automatic owner_t rr_pick(input logic   f_req,
                                       input logic   d_req,
                                       input owner_t last_grant);
        owner_t pick;
        if (f_req && d_req)
            pick = (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        else if (d_req)
            pick = OWN_DATA;
        else
            pick = OWN_FETCH;
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and MSS handshake bundle; the arbiter is the master of the memory side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = MA_ADDR_W,
    parameter int WDATA_W = MA_WDATA_W,
    parameter int RDATA_W = MA_RDATA_W
) ();

    logic               f_req;
    logic [ADDR_W-1:0]  f_addr;
    logic               f_resp;
    logic [RDATA_W-1:0] f_rdata;
    logic               f_err;

    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_addr;
    logic [WDATA_W-1:0] d_wdata;
    logic               d_resp;
    logic               d_err;
    logic [RDATA_W-1:0] d_rdata;

    logic               mem_read_req;
    logic               mem_write_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WDATA_W-1:0] mem_wdata;
    logic [RDATA_W-1:0] mem_rdata;
    logic               mem_resp;

    logic               busy;
    logic               owner;

    modport master (
        input  f_req, f_addr,
        output f_resp, f_rdata, f_err,
        input  d_read, d_write, d_addr, d_wdata,
        output d_resp, d_err, d_rdata,
        output mem_read_req, mem_write_req, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp,
        output busy, owner
    );

    modport slave (
        output f_req, f_addr,
        input  f_resp, f_rdata, f_err,
        output d_read, d_write, d_addr, d_wdata,
        input  d_resp, d_err, d_rdata,
        input  mem_read_req, mem_write_req, mem_addr, mem_wdata,
        output mem_rdata, mem_resp,
        input  busy, owner
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch (read-only) and the load/store
// unit for the single MSS handshake, with a per-request timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = MA_ADDR_W,
    parameter int WDATA_W = MA_WDATA_W,
    parameter int RDATA_W = MA_RDATA_W,
    parameter int TIMEOUT = MA_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    owner_t           last_grant;
    owner_t           own;
    op_t              op;
    logic [CNT_W-1:0] cnt;

    logic   d_any;
    op_t    d_op;
    owner_t pick;
    logic   done;

    // A simultaneous read and write from the data port is resolved as a write.
    assign d_any = bus.d_read | bus.d_write;
    assign d_op  = bus.d_write ? OP_WR : OP_RD;
    assign pick  = rr_pick(bus.f_req, d_any, last_grant);
    assign done  = bus.mem_resp || (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            last_grant        <= OWN_DATA;
            own               <= OWN_FETCH;
            op                <= OP_RD;
            cnt               <= '0;
            bus.mem_read_req  <= 1'b0;
            bus.mem_write_req <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.f_resp        <= 1'b0;
            bus.f_rdata       <= '0;
            bus.f_err         <= 1'b0;
            bus.d_resp        <= 1'b0;
            bus.d_rdata       <= '0;
            bus.d_err         <= 1'b0;
            bus.busy          <= 1'b0;
            bus.owner         <= 1'b0;
        end else begin
            bus.f_resp <= 1'b0;
            bus.d_resp <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.f_req || d_any) begin
                        own       <= pick;
                        bus.owner <= pick;
                        bus.busy  <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                        if (pick == OWN_DATA) begin
                            op                <= d_op;
                            bus.mem_addr      <= bus.d_addr;
                            bus.mem_wdata     <= bus.d_wdata;
                            bus.mem_read_req  <= (d_op == OP_RD);
                            bus.mem_write_req <= (d_op == OP_WR);
                        end else begin
                            op                <= OP_RD;
                            bus.mem_addr      <= bus.f_addr;
                            bus.mem_read_req  <= 1'b1;
                            bus.mem_write_req <= 1'b0;
                        end
                    end
                end

                REQ: begin
                    cnt <= cnt + 1'b1;
                    // A response on the timeout edge still counts as a response.
                    if (done) begin
                        bus.mem_read_req  <= 1'b0;
                        bus.mem_write_req <= 1'b0;
                        state             <= RESP;
                        if (own == OWN_FETCH) begin
                            bus.f_resp  <= 1'b1;
                            bus.f_err   <= ~bus.mem_resp;
                            bus.f_rdata <= bus.mem_resp ? bus.mem_rdata : '0;
                        end else begin
                            bus.d_resp <= 1'b1;
                            bus.d_err  <= ~bus.mem_resp;
                            if (!bus.mem_resp)
                                bus.d_rdata <= '0;
                            else if (op == OP_RD)
                                bus.d_rdata <= bus.mem_rdata;
                        end
                    end
                end

                RESP: begin
                    last_grant <= own;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = MA_ADDR_W;
    localparam int WW = MA_WDATA_W;
    localparam int RW = MA_RDATA_W;
    localparam int TO = MA_TIMEOUT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) bif ();

    mem_arbiter #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Transaction-level model: which ports are waiting and what they asked for.
    bit          f_pend, d_pend;
    bit [AW-1:0] f_a, d_a;
    bit [WW-1:0] d_wd;
    bit          d_wr;
    int          exp_last;   // 0 = fetch, 1 = data
    bit [RW-1:0] exp_f_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic raise_f(input logic [AW-1:0] a);
        f_pend = 1; f_a = a;
        bif.f_req = 1'b1; bif.f_addr = a;
    endtask

    // kind: 0 = read, 1 = write, 2 = read and write together
    task automatic raise_d(input int kind, input logic [AW-1:0] a, input logic [WW-1:0] wd);
        d_pend = 1; d_a = a; d_wd = wd; d_wr = (kind != 0);
        bif.d_read = (kind != 1); bif.d_write = (kind != 0);
        bif.d_addr = a; bif.d_wdata = wd;
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            bif.mem_resp = stray;
            bif.mem_rdata = RW'($urandom);
            @(posedge clk); #1;
            bif.mem_resp = 1'b0;
            check("idle_busy", bif.busy, 0);
            check("idle_noresp", bif.f_resp | bif.d_resp, 0);
            check("idle_noreq", bif.mem_read_req | bif.mem_write_req, 0);
        end
    endtask

    // Serve one grant: MSS answers in request cycle lat (lat > TO means never).
    task automatic do_round(input int lat, input logic [RW-1:0] rd);
        int win, n_exp, hi;
        bit is_wr, timed_out;
        win = (f_pend && d_pend) ? (1 - exp_last) : (d_pend ? 1 : 0);
        is_wr = (win == 1) && d_wr;
        timed_out = (lat > TO);
        n_exp = timed_out ? TO : lat;

        @(posedge clk); #1;
        check("grant_busy", bif.busy, 1);
        check("grant_owner", bif.owner, win);
        check("grant_rdreq", bif.mem_read_req, !is_wr);
        check("grant_wrreq", bif.mem_write_req, is_wr);
        check("grant_addr", bif.mem_addr, win ? d_a : f_a);
        if (is_wr) check("grant_wdata", bif.mem_wdata, d_wd);

        hi = 0;
        for (int k = 1; k <= TO; k++) begin
            if (bif.mem_read_req | bif.mem_write_req) hi++;
            bif.mem_resp = (k == lat);
            bif.mem_rdata = (k == lat) ? rd : RW'($urandom);
            @(posedge clk); #1;
            bif.mem_resp = 1'b0;
            if (k == n_exp) break;
            check("wait_noresp", bif.f_resp | bif.d_resp, 0);
            check("wait_addr", bif.mem_addr, win ? d_a : f_a);
        end

        check("req_cycles", hi, n_exp);
        check("req_drop", bif.mem_read_req | bif.mem_write_req, 0);
        check("resp_win", win ? bif.d_resp : bif.f_resp, 1);
        check("resp_other", win ? bif.f_resp : bif.d_resp, 0);
        check("resp_err", win ? bif.d_err : bif.f_err, timed_out);
        if (win == 0) begin
            exp_f_rdata = timed_out ? '0 : rd;
            check("f_rdata", bif.f_rdata, exp_f_rdata);
        end else begin
            if (!d_wr) check("d_rdata", bif.d_rdata, timed_out ? '0 : rd);
            check("f_rdata_hold", bif.f_rdata, exp_f_rdata);
        end
        exp_last = win;

        @(posedge clk); #1;
        check("resp_single", bif.f_resp | bif.d_resp, 0);
        check("back_idle", bif.busy, 0);
        if (win == 0) begin
            f_pend = 0; bif.f_req = 1'b0;
        end else begin
            d_pend = 0; bif.d_read = 1'b0; bif.d_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        f_pend = 0; d_pend = 0;
        bif.f_req = 1'b0; bif.d_read = 1'b0; bif.d_write = 1'b0;
        bif.mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_last = 1;
        exp_f_rdata = '0;
    endtask

    int lat;
    int r;

    initial begin
        reset = 1'b1;
        bif.f_req = 1'b0; bif.f_addr = '0;
        bif.d_read = 1'b0; bif.d_write = 1'b0; bif.d_addr = '0; bif.d_wdata = '0;
        bif.mem_resp = 1'b0; bif.mem_rdata = '0;
        f_pend = 0; d_pend = 0; exp_last = 1; exp_f_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bif.busy, 0);
        check("rst_owner", bif.owner, 0);
        check("rst_rdreq", bif.mem_read_req, 0);
        check("rst_wrreq", bif.mem_write_req, 0);
        check("rst_addr", bif.mem_addr, 0);
        check("rst_wdata", bif.mem_wdata, 0);
        check("rst_fresp", bif.f_resp, 0);
        check("rst_dresp", bif.d_resp, 0);
        check("rst_frdata", bif.f_rdata, 0);
        check("rst_drdata", bif.d_rdata, 0);
        check("rst_ferr", bif.f_err, 0);
        check("rst_derr", bif.d_err, 0);
        reset = 1'b0;

        // Basic fetch read and best-case data write.
        raise_f(14'h0123);
        do_round(3, 8'h5A);
        raise_d(1, 14'h3FFF, 16'hBEEF);
        do_round(1, 8'h00);

        // Continuous contention from reset: strict alternation starting with fetch.
        do_reset();
        raise_f(14'h0100);
        raise_d(0, 14'h0200, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            do_round($urandom_range(1, 3), RW'($urandom));
            if (!f_pend) raise_f(AW'($urandom));
            if (!d_pend) raise_d(0, AW'($urandom), 16'h0);
        end
        do_round(1, 8'h11);
        do_round(1, 8'h22);

        // Data read with no MSS answer.
        raise_d(0, 14'h0444, 16'h0);
        do_round(TO + 5, 8'hFF);

        // Reset in the middle of a fetch request.
        raise_f(14'h0555);
        repeat (3) @(posedge clk);
        #1;
        check("mid_reqhi", bif.mem_read_req, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_busy", bif.busy, 0);
        check("mid_rdreq", bif.mem_read_req, 0);
        check("mid_fresp", bif.f_resp, 0);
        check("mid_addr", bif.mem_addr, 0);
        bif.f_req = 1'b0; f_pend = 0;
        reset = 1'b0; exp_last = 1; exp_f_rdata = '0;
        idle_cycles(2, 1'b0);
        raise_f(14'h0666);
        do_round(2, 8'hC3);

        // Stray MSS response while idle, then an illegal read+write.
        idle_cycles(3, 1'b1);
        raise_d(2, 14'h0777, 16'h1234);
        do_round(2, 8'h99);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            if (!f_pend && !d_pend) begin
                idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
                r = $urandom_range(0, 2);
                if (r != 1) raise_f(AW'($urandom));
                if (r != 0) raise_d($urandom_range(0, 2), AW'($urandom), WW'($urandom));
            end else begin
                if (!f_pend && $urandom_range(0, 1) == 1) raise_f(AW'($urandom));
                if (!d_pend && $urandom_range(0, 1) == 1)
                    raise_d($urandom_range(0, 2), AW'($urandom), WW'($urandom));
            end
            r = $urandom_range(0, 9);
            lat = (r < 7) ? $urandom_range(1, 4) : $urandom_range(5, TO + 3);
            do_round(lat, RW'($urandom));
        end
        if (f_pend || d_pend) do_round(1, 8'h3C);
        if (f_pend || d_pend) do_round(1, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the 16 KB system memory (MSS) between the instruction-fetch path and the load/store memory interface unit. It accepts one read-only fetch requester and one read/write data requester. Grants one transaction at a time, round-robin on contention, and drives the single MSS request/response handshake. Each response, or a timeout error, returns to the owning requester as a one-cycle pulse.

## Interface
- ADDR_W, 14, system memory byte address width
- WDATA_W, 16, write data width
- RDATA_W, 8, read data width
- TIMEOUT, 16, max cycles a memory request is held before abort (≥2)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request; held until f_resp
- f_addr  in  ADDR_W  fetch address; stable while f_req
- f_resp  out  1  one-cycle fetch completion pulse
- f_rdata  out  RDATA_W  fetch read data; valid with f_resp
- f_err  out  1  timeout flag; valid with f_resp
- d_read, d_write  in  1 each  data-port read/write request; held until d_resp
- d_addr  in  ADDR_W  data address
- d_wdata  in  WDATA_W  store data
- d_resp, d_err  out  1 each  data completion pulse / timeout flag
- d_rdata  out  RDATA_W  load data; valid with d_resp on reads
- mem_read_req, mem_write_req  out  1 each  to MSS
- mem_addr  out  ADDR_W  to MSS
- mem_wdata  out  WDATA_W  to MSS
- mem_rdata  in  RDATA_W  from MSS
- mem_resp  in  1  from MSS
- busy  out  1  high in any state other than IDLE
- owner  out  1  0 = fetch, 1 = data; valid while busy

## Operation
- States: IDLE, REQ, RESP. All outputs registered.
- IDLE: if exactly one port requests, grant it. If both request, grant the port not granted last (last_grant register). Latch addr, wdata, op, owner. Clear timeout counter. Go to REQ.
- d_read and d_write both high is illegal; treat as write.
- REQ: assert mem_read_req or mem_write_req per latched op. Hold mem_addr/mem_wdata stable. Counter increments each cycle.
  - mem_resp sampled high: drop request, capture mem_rdata (reads), go to RESP with err=0.
  - Counter reaches TIMEOUT−1 with mem_resp low: drop request, rdata=0, go to RESP with err=1.
  - mem_resp and timeout on the same edge: response wins, err=0.
- RESP: pulse owner's resp for exactly one cycle with rdata/err. Update last_grant = owner. Go to IDLE.
- mem_resp outside REQ is ignored.
- Requesters sample their resp and deassert req at that same edge. IDLE therefore never re-grants a completed request.
- mem_addr/mem_wdata hold last value between transactions. f_rdata/d_rdata hold until their next resp.
- Reset: state IDLE, last_grant = data (fetch wins first tie), counter 0, all outputs 0. An in-flight transaction is dropped with no resp.

## Timing
- Edge E0: request sampled in IDLE. mem_*_req high from E0.
- mem_resp sampled at edge En: resp pulse during cycle after En. IDLE after En+1.
- Best case (mem_resp in first REQ cycle): request → resp pulse 2 cycles; back-to-back grants every 3 cycles.
- Timeout: mem_*_req high for exactly TIMEOUT cycles, then err pulse.
- Fairness: under continuous contention, grants strictly alternate.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, REQ, RESP), owner enum (OWN_FETCH, OWN_DATA), op enum (OP_RD, OP_WR)
  - width constants
  - rr_pick function (two requests + last_grant → owner)
- No sub-module; single FSM plus timeout counter of width $clog2(TIMEOUT).

## Test plan
- f_req, f_addr=0x0123; MSS responds 3 cycles after mem_read_req with 0x5A → mem_addr=0x0123, f_resp pulse one cycle, f_rdata=0x5A, f_err=0.
- d_write, d_addr=0x3FFF, d_wdata=0xBEEF; mem_resp in first REQ cycle → mem_write_req 1 cycle, mem_wdata=0xBEEF, d_resp 2 cycles after request.
- f_req and d_read held continuously from reset → grants fetch, data, fetch, data; owner alternates.
- d_read; MSS never responds → mem_read_req high exactly 16 cycles, then d_resp with d_err=1, d_rdata=0.
- reset asserted in REQ mid-read → next cycle all outputs 0, no resp pulse; subsequent f_req served normally.
- mem_resp pulse while IDLE, then d_read and d_write both high → stray resp ignored; transaction issued as write.
